// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot FSM state encodings and the oversampling ratio,
// common to the transmitter and the matching receiver.
package uart_pkg;

  localparam logic [4:0] ST_IDLE   = 5'b00001;
  localparam logic [4:0] ST_START  = 5'b00010;
  localparam logic [4:0] ST_DATA   = 5'b00100;
  localparam logic [4:0] ST_PARITY = 5'b01000;
  localparam logic [4:0] ST_STOP   = 5'b10000;

  localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, N_BITS_DATA data bits LSB first, optional even parity
// (enabled by defining UART_TX_PARITY_EN), stop period of SB_TICK baud ticks.
module uart_tx
  import uart_pkg::*;
#(
  parameter int N_BITS_DATA  = 8,
  parameter int SB_TICK      = 16,
  parameter int N_BITS_TICK  = 5,
  parameter int N_BITS_STATE = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   s_tick_i,
  input  logic                   tx_start_i,
  input  logic [N_BITS_DATA-1:0] data_i,
  output logic                   tx_o,
  output logic                   tx_done_tick_o,
  output logic                   busy_o
);

  localparam int N_BITS_CNT = (N_BITS_DATA > 1) ? $clog2(N_BITS_DATA) : 1;

  localparam logic [N_BITS_TICK-1:0] S_LAST    = N_BITS_TICK'(OVERSAMPLE - 1);
  localparam logic [N_BITS_TICK-1:0] S_STOP    = N_BITS_TICK'(SB_TICK - 1);
  localparam logic [N_BITS_CNT-1:0]  N_LAST    = N_BITS_CNT'(N_BITS_DATA - 1);
  localparam logic [N_BITS_TICK-1:0] S_ONE     = N_BITS_TICK'(1);
  localparam logic [N_BITS_CNT-1:0]  N_ONE     = N_BITS_CNT'(1);

  logic [N_BITS_STATE-1:0] state_q, state_d;
  logic [N_BITS_TICK-1:0]  s_q, s_d;
  logic [N_BITS_CNT-1:0]   n_q, n_d;
  logic [N_BITS_DATA-1:0]  b_q, b_d;
  logic                    tx_q, tx_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;

  function automatic logic even_parity(input logic [N_BITS_DATA-1:0] d);
    return ^d;
  endfunction
`endif

  // Next-state, counter and shift-register logic; counters move only on baud ticks.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_start_i) begin
          b_d     = data_i;
          s_d     = '0;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d = even_parity(data_i);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (s_tick_i) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + S_ONE;
          end
        end else begin
          s_d = s_q;
        end
      end
      ST_DATA: begin
        if (s_tick_i) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              n_d = n_q + N_ONE;
            end
          end else begin
            s_d = s_q + S_ONE;
          end
        end else begin
          s_d = s_q;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (s_tick_i) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + S_ONE;
          end
        end else begin
          s_d = s_q;
        end
      end
`endif
      ST_STOP: begin
        if (s_tick_i) begin
          if (s_q == S_STOP) begin
            s_d     = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            s_d = s_q + S_ONE;
          end
        end else begin
          s_d = s_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        s_d     = '0;
        n_d     = '0;
      end
    endcase
  end

  // The line register takes the level of the state being entered so line and state edges coincide.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the accepted byte, held for the whole frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign tx_o           = tx_q;
  assign tx_done_tick_o = done_q;
  assign busy_o         = busy_q;

endmodule
